// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line, bit strobe and parallel valid/ready bundle for serial_frame_rx.
//   bit_en       strobe; serial_in is sampled only when high
//   serial_in    serial line, idles high
//   msb_first    bit-order select, captured at the start bit
//   out_ready    consumer accepts the held word
//   parallel_out received word, index 0 is the MSB
//   out_valid    parallel_out holds an unconsumed word
//   parity_err   one-cycle pulse, parity mismatch, word dropped
//   frame_err    one-cycle pulse, stop bit low, word dropped
//   overrun      one-cycle pulse, holding register full, new word dropped
interface serial_frame_rx_if #(
   parameter int WIDTH = 4
);
   logic             bit_en;
   logic             serial_in;
   logic             msb_first;
   logic             out_ready;
   logic [0:WIDTH-1] parallel_out;
   logic             out_valid;
   logic             parity_err;
   logic             frame_err;
   logic             overrun;
   modport master (
      output bit_en, serial_in, msb_first, out_ready,
      input  parallel_out, out_valid, parity_err, frame_err, overrun
   );
   modport slave (
      input  bit_en, serial_in, msb_first, out_ready,
      output parallel_out, out_valid, parity_err, frame_err, overrun
   );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobed serial frame receiver (start, WIDTH data, optional even parity, stop) with a valid/ready output.
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    serial_frame_rx_if.slave: line/strobe/order/ready in, word/valid/error pulses out
module serial_frame_rx #(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input logic              clk_i,
   input logic              rst_i,
   serial_frame_rx_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] DATA   = 3'd1;
   localparam logic [2:0] PARITY = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
   localparam logic [2:0] BREAK  = 3'd4;
   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [0:WIDTH-1] shreg_q, shreg_d;
   logic [0:WIDTH-1] dout_q, dout_d;
   logic             msb_q, msb_d;
   logic             par_q, par_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             good;
   logic             load;
   // par_q accumulates the XOR of every data bit and the parity bit; it must end at 0.
   // good is only meaningful on the stop sample: stop high and parity clean.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      msb_d   = msb_q;
      par_d   = par_q;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      good    = bus.serial_in & ~(PARITY_EN & par_q);
      load    = 1'b0;
      if (bus.bit_en) begin
         case (state_q)
            IDLE: begin
               if (!bus.serial_in) begin
                  state_d = DATA;
                  cnt_d   = '0;
                  msb_d   = bus.msb_first;
                  par_d   = 1'b0;
               end
            end
            DATA: begin
               // MSB-first shifts toward index 0 so the first bit ends at [0]; LSB-first the other way.
               shreg_d = msb_q ? {shreg_q[1:WIDTH-1], bus.serial_in}
                               : {bus.serial_in, shreg_q[0:WIDTH-2]};
               par_d   = par_q ^ bus.serial_in;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
               par_d   = par_q ^ bus.serial_in;
               state_d = STOP;
            end
            STOP: begin
               state_d = bus.serial_in ? IDLE : BREAK;
               ferr_d  = ~bus.serial_in;
               perr_d  = bus.serial_in & PARITY_EN & par_q;
               // Accepting the held word on this same cycle frees the register for the new one.
               load    = good & (~valid_q | bus.out_ready);
               ovr_d   = good & valid_q & ~bus.out_ready;
            end
            BREAK: begin
               if (bus.serial_in) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      dout_d  = load ? shreg_q : dout_q;
      valid_d = load | (valid_q & ~bus.out_ready);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         msb_q   <= 1'b0;
         par_q   <= 1'b0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         msb_q   <= msb_d;
         par_q   <= par_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end
   assign bus.parallel_out = dout_q;
   assign bus.out_valid    = valid_q;
   assign bus.parity_err   = perr_q;
   assign bus.frame_err    = ferr_q;
   assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed vectors for serial_frame_rx (WIDTH=4 with parity, WIDTH=8 without).
module tb_serial_frame_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   gap = 0;
   int   perr_n = 0;
   int   ferr_n = 0;
   int   ovr_n = 0;
   int   p0, f0, o0;
   logic pre_valid;
   serial_frame_rx_if #(.WIDTH(4)) a ();
   serial_frame_rx_if #(.WIDTH(8)) b ();
   serial_frame_rx #(.WIDTH(4), .PARITY_EN(1'b1)) dut4 (.clk_i(clk), .rst_i(rst), .bus(a));
   serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0)) dut8 (.clk_i(clk), .rst_i(rst), .bus(b));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      perr_n += int'(a.parity_err);
      ferr_n += int'(a.frame_err);
      ovr_n  += int'(a.overrun);
   end
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask
   task automatic send(input logic v);
      a.serial_in = v;
      a.bit_en    = 1'b1;
      @(negedge clk);
      a.bit_en    = 1'b0;
      a.serial_in = 1'b1;
      repeat (gap) @(negedge clk);
   endtask
   task automatic frame4(input logic [3:0] d, input logic p, input logic s, input bit rdy_stop = 1'b0);
      send(1'b0);
      for (int i = 3; i >= 0; i--) send(d[i]);
      send(p);
      pre_valid = a.out_valid;
      if (rdy_stop) a.out_ready = 1'b1;
      send(s);
      if (rdy_stop) a.out_ready = 1'b0;
   endtask
   task automatic consume();
      a.out_ready = 1'b1;
      @(negedge clk);
      a.out_ready = 1'b0;
   endtask
   initial begin
      a.bit_en = 1'b0; a.serial_in = 1'b1; a.msb_first = 1'b1; a.out_ready = 1'b0;
      b.bit_en = 1'b0; b.serial_in = 1'b1; b.msb_first = 1'b1; b.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dout", 32'(a.parallel_out), 32'h0);
      check("rst_valid", 32'(a.out_valid), 32'h0);
      check("rst_perr", 32'(a.parity_err), 32'h0);
      check("rst_ferr", 32'(a.frame_err), 32'h0);
      check("rst_ovr", 32'(a.overrun), 32'h0);
      check("rst_dout8", 32'(b.parallel_out), 32'h0);
      rst = 1'b0;
      frame4(4'b1011, 1'b1, 1'b1);
      check("msb_pre_valid", 32'(pre_valid), 32'h0);
      check("msb_dout", 32'(a.parallel_out), 32'hB);
      check("msb_valid", 32'(a.out_valid), 32'h1);
      check("msb_errs", {29'd0, a.parity_err, a.frame_err, a.overrun}, 32'h0);
      consume();
      check("accept_clears", 32'(a.out_valid), 32'h0);
      a.msb_first = 1'b0;
      frame4(4'b1011, 1'b1, 1'b1);
      check("lsb_dout", 32'(a.parallel_out), 32'hD);
      check("lsb_valid", 32'(a.out_valid), 32'h1);
      consume();
      gap = 2;
      frame4(4'b1011, 1'b1, 1'b1);
      gap = 0;
      check("slow_pre_valid", 32'(pre_valid), 32'h0);
      check("slow_dout", 32'(a.parallel_out), 32'hD);
      check("slow_valid", 32'(a.out_valid), 32'h1);
      consume();
      a.msb_first = 1'b1;
      frame4(4'b1011, 1'b0, 1'b1);
      check("perr_pulse", 32'(a.parity_err), 32'h1);
      check("perr_valid", 32'(a.out_valid), 32'h0);
      @(negedge clk);
      check("perr_once", 32'(a.parity_err), 32'h0);
      frame4(4'b1011, 1'b1, 1'b0);
      check("ferr_pulse", 32'(a.frame_err), 32'h1);
      check("ferr_valid", 32'(a.out_valid), 32'h0);
      check("ferr_no_perr", 32'(a.parity_err), 32'h0);
      @(negedge clk);
      check("ferr_once", 32'(a.frame_err), 32'h0);
      f0 = ferr_n;
      repeat (7) send(1'b0);
      send(1'b1);
      frame4(4'b0110, 1'b0, 1'b1);
      check("break_dout", 32'(a.parallel_out), 32'h6);
      check("break_valid", 32'(a.out_valid), 32'h1);
      @(negedge clk);
      check("break_no_start", 32'(ferr_n - f0), 32'h0);
      consume();
      frame4(4'b1011, 1'b1, 1'b1);
      frame4(4'b0110, 1'b0, 1'b1);
      check("ovr_pulse", 32'(a.overrun), 32'h1);
      check("ovr_held", 32'(a.parallel_out), 32'hB);
      check("ovr_valid", 32'(a.out_valid), 32'h1);
      @(negedge clk);
      check("ovr_once", 32'(a.overrun), 32'h0);
      consume();
      frame4(4'b1011, 1'b1, 1'b1);
      frame4(4'b0110, 1'b0, 1'b1, 1'b1);
      check("swap_dout", 32'(a.parallel_out), 32'h6);
      check("swap_valid", 32'(a.out_valid), 32'h1);
      check("swap_no_ovr", 32'(a.overrun), 32'h0);
      consume();
      send(1'b0); send(1'b1); send(1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_dout", 32'(a.parallel_out), 32'h0);
      check("midrst_valid", 32'(a.out_valid), 32'h0);
      p0 = perr_n; f0 = ferr_n; o0 = ovr_n;
      frame4(4'b0110, 1'b0, 1'b1);
      check("midrst_frame", 32'(a.parallel_out), 32'h6);
      @(negedge clk);
      check("midrst_no_pulse", 32'((perr_n - p0) + (ferr_n - f0) + (ovr_n - o0)), 32'h0);
      consume();
      begin
         logic [9:0] line;
         line = 10'b0101001011;
         for (int i = 9; i >= 0; i--) begin
            if (i == 0) pre_valid = b.out_valid;
            b.serial_in = line[i];
            b.bit_en    = 1'b1;
            @(negedge clk);
         end
         b.bit_en    = 1'b0;
         b.serial_in = 1'b1;
      end
      check("w8_pre_valid", 32'(pre_valid), 32'h0);
      check("w8_dout", 32'(b.parallel_out), 32'hA5);
      check("w8_valid", 32'(b.out_valid), 32'h1);
      check("w8_errs", {29'd0, b.parity_err, b.frame_err, b.overrun}, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
